// File: rtl/timer_tick_gen.sv
// Multi-channel prescaler and count-enable generator for the APB timer.
// Each channel ticks cnt_en every 2^div_val cycles (or every cycle) and can be frozen by a shared debug halt.
module timer_tick_gen #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       timer_en,
  input  logic [NUM_CH-1:0]       div_en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       restart,
  input  logic                    dbg_mode,
  input  logic                    halt_req,
  input  logic [NUM_CH-1:0]       halt_mask,
  output logic [NUM_CH-1:0]       cnt_en,
  output logic                    halt_ack,
  output logic [NUM_CH-1:0]       halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;

  halt_state_e state_q, state_d;

  logic              halt_en;
  logic [NUM_CH-1:0] frz;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] term;

  assign halt_en = dbg_mode & halt_req;
  assign frz     = {NUM_CH{halt_en}} & ~halt_mask;
  assign halted  = frz;

  // Shared halt handshake; halt_ack is decoded straight from the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_en)  state_d = ST_HALTED;
      ST_HALTED: if (!halt_en) state_d = ST_RUN;
      default:                 state_d = ST_RUN;
    endcase
  end

  assign halt_ack = (state_q == ST_HALTED);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [DIV_W-1:0] dv_sel;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] pre_cnt;

    assign dv_sel = div_val[n*DIV_W +: DIV_W];

    // Selects at or above CNT_W saturate to the full-range limit rather than wrapping.
    always_comb begin
      lim = '1;
      if (int'(dv_sel) < CNT_W) lim = CNT_W'((1 << dv_sel) - 1);
    end

    // >= rather than == so a limit lowered mid-count still terminates on the next active cycle.
    assign term[n]   = (pre_cnt >= lim);
    assign active[n] = timer_en[n] & ~frz[n];
    assign cnt_en[n] = active[n] & (~div_en[n] | term[n]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pre_cnt <= '0;
      end else if (~timer_en[n] | ~div_en[n] | restart[n]) begin
        pre_cnt <= '0;
      end else if (frz[n]) begin
        pre_cnt <= pre_cnt;
      end else if (term[n]) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + CNT_W'(1);
      end
    end
  end

endmodule
